// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: feeds one operand bit per clock to an external 1-bit ALU slice.
// Optional macro SLT_OVF_CORRECT_EN selects the overflow-corrected signed less bit for SLT.
module alu_serial_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             s_a,
    output logic             s_b,
    output logic             s_ain,
    output logic             s_bin,
    output logic             s_cin,
    output logic             s_less,
    output logic [1:0]       s_op,
    input  logic             s_o,
    input  logic             s_cout,
    input  logic             s_set,
    input  logic             s_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_supported(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_supported = 1'b1;
            default:                                              op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic op_arith(input logic [3:0] c);
        case (c)
            4'b0010, 4'b0110, 4'b0111: op_arith = 1'b1;
            default:                   op_arith = 1'b0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]        ctl_q, ctl_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
    logic              sup_s, less_s;

    assign sup_s = op_supported(ctl_q);

`ifdef SLT_OVF_CORRECT_EN
    assign less_s = s_set ^ s_ovf;
`else
    assign less_s = s_set;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= {IW{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            ctl_q    <= 4'b0000;
            carry_q  <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctl_q    <= ctl_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state, slice drive and per-bit result collection.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        ctl_d    = ctl_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        s_a      = 1'b0;
        s_b      = 1'b0;
        s_ain    = 1'b0;
        s_bin    = 1'b0;
        s_cin    = 1'b0;
        s_less   = 1'b0;
        s_op     = 2'b00;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    ctl_d   = alu_ctl;
                    idx_d   = {IW{1'b0}};
                    carry_d = alu_ctl[2];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Unsupported opcodes keep the slice quiet and collect zeros.
                if (sup_s) begin
                    s_a   = a_q[idx_q];
                    s_b   = b_q[idx_q];
                    s_ain = ctl_q[3];
                    s_bin = ctl_q[2];
                    s_op  = ctl_q[1:0];
                    s_cin = carry_q;
                end else begin
                    s_cin = 1'b0;
                end
                carry_d = s_cout;
                if ((idx_q == LAST_IDX) && (ctl_q == OP_SLT)) begin
                    result_d = {{(WIDTH-1){1'b0}}, less_s};
                end else begin
                    result_d[idx_q] = sup_s & s_o;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    zero_d  = (result_d == {WIDTH{1'b0}});
                    if (op_arith(ctl_q)) begin
                        ovf_d  = s_ovf;
                        cout_d = s_cout;
                    end else begin
                        ovf_d  = 1'b0;
                        cout_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: slice model, arithmetic reference model, directed vectors.
module tb_alu_serial_sequencer;

    localparam int W = 64;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0] alu_ctl;
    logic s_a, s_b, s_ain, s_bin, s_cin, s_less, s_o, s_cout, s_set, s_ovf;
    logic [1:0] s_op;
    logic zero, carry_out, overflow;
    logic [7:0] s_pack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctl(alu_ctl),
        .s_a(s_a), .s_b(s_b), .s_ain(s_ain), .s_bin(s_bin), .s_cin(s_cin),
        .s_less(s_less), .s_op(s_op),
        .s_o(s_o), .s_cout(s_cout), .s_set(s_set), .s_ovf(s_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow)
    );

    assign s_pack = {s_a, s_b, s_ain, s_bin, s_cin, s_less, s_op};

    // Classic 1-bit ALU slice with input inversion, carry chain and MSB overflow detect.
    always_comb begin
        logic aa, bb, sum;
        aa     = s_a ^ s_ain;
        bb     = s_b ^ s_bin;
        sum    = aa ^ bb ^ s_cin;
        s_cout = (aa & bb) | (aa & s_cin) | (bb & s_cin);
        s_set  = sum;
        s_ovf  = s_cin ^ s_cout;
        case (s_op)
            2'b00:   s_o = aa & bb;
            2'b01:   s_o = aa | bb;
            2'b10:   s_o = sum;
            default: s_o = s_less;
        endcase
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic is_supported(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Whole-word reference: returns {overflow, carry_out, result}.
    function automatic logic [W+1:0] calc(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] s;
        logic v, less;
        case (c)
            4'b0000: return {2'b00, av & bv};
            4'b0001: return {2'b00, av | bv};
            4'b1100: return {2'b00, ~(av | bv)};
            4'b0010: begin
                s = {1'b0, av} + {1'b0, bv};
                v = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
                return {v, s};
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
                v = (av[W-1] != bv[W-1]) && (s[W-1] != av[W-1]);
`ifdef SLT_OVF_CORRECT_EN
                less = ($signed(av) < $signed(bv));
`else
                less = s[W-1];
`endif
                if (c == 4'b0111) return {v, s[W], {(W-1){1'b0}}, less};
                return {v, s};
            end
            default: return {(W+2){1'b0}};
        endcase
    endfunction

    // Carry entering bit i of the (optionally inverted) operand sum.
    function automatic logic carry_in(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv, input int i);
        logic [W:0] mask, aa, bb, sum;
        mask = ((W+1)'(1) << i) - (W+1)'(1);
        aa   = {1'b0, (c[3] ? ~av : av)} & mask;
        bb   = {1'b0, (c[2] ? ~bv : bv)} & mask;
        sum  = aa + bb + {{W{1'b0}}, c[2]};
        return sum[i];
    endfunction

    int m_phase, m_idx;
    logic [W-1:0] m_a, m_b, m_r;
    logic [3:0] m_ctl;
    logic m_z, m_c, m_v;

    // Transaction-level model of the handshake and expected results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE; m_idx <= 0;
            m_r <= '0; m_z <= 1'b0; m_c <= 1'b0; m_v <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (in_valid) begin
                    m_a <= a; m_b <= b; m_ctl <= alu_ctl; m_idx <= 0; m_phase <= P_RUN;
                end
                P_RUN: if (m_idx == W - 1) begin
                    m_phase <= P_DONE;
                    {m_v, m_c, m_r} <= calc(m_ctl, m_a, m_b);
                    m_z <= (calc(m_ctl, m_a, m_b) & {2'b00, {W{1'b1}}}) == '0;
                end else begin
                    m_idx <= m_idx + 1;
                end
                P_DONE: if (out_ready) m_phase <= P_IDLE;
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        check("in_ready", in_ready, m_phase == P_IDLE);
        check("out_valid", out_valid, m_phase == P_DONE);
        if (m_phase == P_RUN && is_supported(m_ctl))
            check("slice_drive", s_pack, {m_a[m_idx], m_b[m_idx], m_ctl[3], m_ctl[2],
                                          carry_in(m_ctl, m_a, m_b, m_idx), 1'b0, m_ctl[1:0]});
        else
            check("slice_quiet", s_pack, 8'h00);
        if (m_phase == P_DONE) begin
            check("result", result, m_r);
            check("flags", {zero, carry_out, overflow}, {m_z, m_c, m_v});
        end
        if (rst) check("reset_outputs", {result, zero, carry_out, overflow}, '0);
    end

    task automatic run_op(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ez, input logic ec, input logic ev,
                          input bit hold, input string nm);
        int n;
        bit rdy, seen;
        rdy = 1'b0; seen = 1'b0; n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) begin rdy = 1'b1; break; end
        end
        check({nm, "_ready"}, rdy, 1);
        if (!rdy) return;
        in_valid = 1'b1; a = av; b = bv; alu_ctl = c;
        if (hold) out_ready = 1'b0;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        for (int k = 1; k <= W + 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin seen = 1'b1; n = k; break; end
        end
        check({nm, "_latency"}, n, W);
        if (!seen) return;
        check({nm, "_result"}, result, er);
        check({nm, "_zcv"}, {zero, carry_out, overflow}, {ez, ec, ev});
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check({nm, "_held_result"}, result, er);
                check({nm, "_held_ready"}, {in_ready, out_valid}, 2'b01);
            end
            out_ready = 1'b1; in_valid = 1'b0;
        end
        @(posedge clk); #1;
        check({nm, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        bit saw;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_ctl = 4'b0000; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_zcv", {zero, carry_out, overflow}, 3'b000);
        check("rst_out_valid", out_valid, 0);
        check("rst_slice", s_pack, 8'h00);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1);

        run_op(4'b0010, 64'd5, 64'd3, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0, "add_5_3");
        run_op(4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, "sub_ovf");
        run_op(4'b0110, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, "sub_eq");
`ifdef SLT_OVF_CORRECT_EN
        run_op(4'b0111, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b0, 1'b1, 1'b1, 1'b0, "slt_min");
`else
        run_op(4'b0111, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, "slt_min");
`endif
        run_op(4'b0111, 64'd3, 64'd5, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, "slt_3_5");
        run_op(4'b0000, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000,
               64'h0F00_0F00_1234_0000, 1'b0, 1'b0, 1'b0, 1'b0, "and");
        run_op(4'b1100, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
               64'd0, 1'b1, 1'b0, 1'b0, 1'b0, "nor_zero");
        run_op(4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, "nor_ones");
        run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, "add_wrap");
        run_op(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, "unsupported");

        // Abort an ADD at bit index 20 with a reset pulse.
        @(negedge clk);
        check("abort_ready", in_ready, 1);
        in_valid = 1'b1; a = 64'h0123_4567_89AB_CDEF; b = 64'h0000_0000_0010_0000; alu_ctl = 4'b0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bit20_ab", {s_a, s_b}, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("abort_rst_outputs", {result, zero, carry_out, overflow}, '0);
        check("abort_rst_hs", {in_ready, out_valid, s_pack}, {2'b10, 8'h00});
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_next", {in_ready, out_valid}, 2'b10);
        saw = 1'b0;
        repeat (W + 8) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("abort_no_out_valid", saw, 0);
        run_op(4'b0010, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, "add_after_abort");

        run_op(4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b1, "or_hold");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
